// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock into a
// register file, read back through a stalling request/ack port.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   key_valid/ready   cipher key handshake, key_in = {w0,w1,w2,w3}
//   busy, done        expansion running / 1-cycle pulse at last round
//   rk_req/idx        round-key read request, held until rk_ack
//   rk_ack/data/err   read response; err flags idx > NR
module key_schedule_ctrl #(
  parameter int NR   = 10,
  parameter int IDXW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            key_valid,
  output logic            key_ready,
  input  logic [127:0]    key_in,
  output logic            busy,
  output logic            done,
  input  logic            rk_req,
  input  logic [IDXW-1:0] rk_idx,
  output logic            rk_ack,
  output logic [127:0]    rk_data,
  output logic            rk_err
);

  localparam logic [IDXW-1:0] NR_I = IDXW'(NR);
  localparam logic [IDXW-1:0] ONE  = IDXW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_READY
  } state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] avail_q, avail_d;
  logic [IDXW-1:0] round_q, round_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            done_q, done_d;
  logic [127:0]    rk_q [NR+1];

  logic            accept;
  logic            wr_en;
  logic [127:0]    prev_rk;
  logic [127:0]    next_rk;
  logic [31:0]     t, w0, w1, w2, w3;

  logic            rd_go, rd_err, rd_ok;
  logic            rk_ack_q;
  logic            rk_err_q;
  logic [127:0]    rk_data_q;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as b^254 (0 maps to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    logic [7:0] v;
    s = b;
    v = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      v = gmul(v, s);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  always_comb begin
    prev_rk = rk_q[round_q - ONE];
    t  = subword({prev_rk[23:0], prev_rk[31:24]})
       ^ {rcon_q, 24'h0};
    w0 = prev_rk[127:96] ^ t;
    w1 = prev_rk[95:64]  ^ w0;
    w2 = prev_rk[63:32]  ^ w1;
    w3 = prev_rk[31:0]   ^ w2;
    next_rk = {w0, w1, w2, w3};
  end

  always_comb begin
    state_d   = state_q;
    avail_d   = avail_q;
    round_d   = round_q;
    rcon_d    = rcon_q;
    done_d    = 1'b0;
    key_ready = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      S_IDLE, S_READY: begin
        key_ready = 1'b1;
        if (key_valid) begin
          accept  = 1'b1;
          avail_d = ONE;
          round_d = ONE;
          rcon_d  = 8'h01;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        avail_d = round_q + ONE;
        round_d = round_q + ONE;
        rcon_d  = xtime(rcon_q);
        if (round_q == NR_I) begin
          done_d  = 1'b1;
          state_d = S_READY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      avail_q <= '0;
      round_q <= '0;
      rcon_q  <= 8'h01;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      avail_q <= avail_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      done_q  <= done_d;
    end
  end

  // Key storage keeps its contents across reset; avail gates reads.
  always_ff @(posedge clk) begin
    if (!reset && accept) rk_q[0] <= key_in;
    if (!reset && wr_en)  rk_q[round_q] <= next_rk;
  end

  // The cycle right after an ack ignores the still-held request.
  always_comb begin
    rd_go  = rk_req && !rk_ack_q;
    rd_err = rk_idx > NR_I;
    rd_ok  = !rd_err && (rk_idx < avail_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rk_ack_q  <= 1'b0;
      rk_err_q  <= 1'b0;
      rk_data_q <= '0;
    end else begin
      rk_ack_q <= rd_go && (rd_err || rd_ok);
      if (rd_go && rd_err) begin
        rk_err_q  <= 1'b1;
        rk_data_q <= '0;
      end else if (rd_go && rd_ok) begin
        rk_err_q  <= 1'b0;
        rk_data_q <= rk_q[rk_idx];
      end
    end
  end

  assign done    = done_q;
  assign rk_ack  = rk_ack_q;
  assign rk_err  = rk_err_q;
  assign rk_data = rk_data_q;

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Bench for key_schedule_ctrl: directed FIPS-197 cases plus
// random traffic checked every cycle against a schedule model.
module tb_key_schedule_ctrl;

  typedef logic [10:0][127:0] sched_t;

  localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_valid = 1'b0;
  logic         key_ready;
  logic [127:0] key_in = '0;
  logic         busy;
  logic         done;
  logic         rk_req = 1'b0;
  logic [3:0]   rk_idx = '0;
  logic         rk_ack;
  logic [127:0] rk_data;
  logic         rk_err;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [7:0] sb [256];

  int           m_avail = 0;
  bit           m_exp = 1'b0;
  bit           m_done = 1'b0;
  bit           m_ack = 1'b0;
  bit           m_err = 1'b0;
  logic [127:0] m_data = '0;
  sched_t       m_sched = '0;

  key_schedule_ctrl #(.NR(10), .IDXW(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .busy      (busy),
    .done      (done),
    .rk_req    (rk_req),
    .rk_idx    (rk_idx),
    .rk_ack    (rk_ack),
    .rk_data   (rk_data),
    .rk_err    (rk_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Textbook word-by-word expansion of 44 words.
  function automatic sched_t expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [79:0] rcs;
    sched_t      s;
    rcs = 80'h01020408102040801b36;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0)
        tmp = subw({tmp[23:0], tmp[31:24]})
            ^ {rcs[79-8*(i/4-1) -: 8], 24'h0};
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkd(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: S-box by brute-force inverse search, then per-edge update.
  initial begin
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8]
             ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sb[x] = s;
    end
    forever begin
      @(posedge clk);
      if (reset) begin
        m_avail = 0;
        m_exp   = 1'b0;
        m_done  = 1'b0;
        m_ack   = 1'b0;
        m_err   = 1'b0;
        m_data  = '0;
      end else begin
        if (rk_req && !m_ack) begin
          if (rk_idx > 4'd10) begin
            m_ack  = 1'b1;
            m_err  = 1'b1;
            m_data = '0;
          end else if (int'(rk_idx) < m_avail) begin
            m_ack  = 1'b1;
            m_err  = 1'b0;
            m_data = m_sched[rk_idx];
          end else begin
            m_ack = 1'b0;
          end
        end else begin
          m_ack = 1'b0;
        end
        m_done = 1'b0;
        if (m_exp) begin
          m_avail++;
          if (m_avail == 11) begin
            m_exp  = 1'b0;
            m_done = 1'b1;
          end
        end else if (key_valid) begin
          m_sched = expand(key_in);
          m_avail = 1;
          m_exp   = 1'b1;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk1("key_ready", key_ready, !m_exp);
      chk1("busy", busy, m_exp);
      chk1("done", done, m_done);
      chk1("rk_ack", rk_ack, m_ack);
      chk1("rk_err", rk_err, m_err);
      chkd("rk_data", rk_data, m_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic offer_key(input logic [127:0] k);
    key_in    = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    tick();
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
    end
    chki("idle_wait", ok, 1);
    tick();
  endtask

  task automatic wait_ack(input int lim, output logic [127:0] d,
                          output logic e, output int lat);
    lat = -1;
    d   = '0;
    e   = 1'b0;
    for (int c = 0; c < lim; c++) begin
      @(posedge clk);
      #2;
      key_valid = 1'b0;
      @(negedge clk);
      if (rk_ack === 1'b1) begin
        lat = c;
        d   = rk_data;
        e   = rk_err;
        break;
      end
    end
  endtask

  task automatic end_read();
    @(posedge clk);
    #2;
    rk_req = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [3:0] idx, output logic [127:0] d,
                    output logic e, output int lat);
    rk_idx = idx;
    rk_req = 1'b1;
    wait_ack(40, d, e, lat);
    end_read();
  endtask

  initial begin
    sched_t       s;
    logic [127:0] d;
    logic [127:0] k;
    logic         e;
    int           lat;
    int           nack;
    int           ndone;
    bit           idle;

    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    @(negedge clk);
    chk1("rst_key_ready", key_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_rk_ack", rk_ack, 1'b0);
    chk1("rst_rk_err", rk_err, 1'b0);
    chkd("rst_rk_data", rk_data, '0);
    tick();

    s = expand(K_FIPS);
    chkd("model_fips_rk1", s[1], F_RK1);
    chkd("model_fips_rk10", s[10], F_RK10);
    s = expand('0);
    chkd("model_zero_rk1", s[1], Z_RK1);
    chkd("model_zero_rk10", s[10], Z_RK10);

    rd(4'd12, d, e, lat);
    chki("idle_err_lat", lat, 0);
    chk1("idle_err_flag", e, 1'b1);
    chkd("idle_err_data", d, '0);

    offer_key(K_FIPS);
    wait_done(lat);
    chki("fips_done_lat", lat, 10);
    rd(4'd1, d, e, lat);
    chkd("fips_rk1", d, F_RK1);
    chki("fips_rk1_lat", lat, 0);
    rd(4'd10, d, e, lat);
    chkd("fips_rk10", d, F_RK10);
    rd(4'd11, d, e, lat);
    chki("ready_err_lat", lat, 0);
    chk1("ready_err_flag", e, 1'b1);
    chkd("ready_err_data", d, '0);
    rd(4'd15, d, e, lat);
    chk1("ready_err15_flag", e, 1'b1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    k = {$urandom, $urandom, $urandom, $urandom};
    s = expand(k);
    key_in    = k;
    key_valid = 1'b1;
    rk_idx    = 4'd5;
    rk_req    = 1'b1;
    wait_ack(20, d, e, lat);
    end_read();
    chki("early_rd_lat", lat, 6);
    chkd("early_rd_data", d, s[5]);
    chk1("early_rd_err", e, 1'b0);
    wait_idle();

    k = {$urandom, $urandom, $urandom, $urandom};
    s = expand(k);
    offer_key(k);
    rd(4'd11, d, e, lat);
    chki("exp_err_lat", lat, 0);
    chk1("exp_err_flag", e, 1'b1);
    offer_key({$urandom, $urandom, $urandom, $urandom});
    wait_idle();
    rd(4'd10, d, e, lat);
    chkd("ignored_key_rk10", d, s[10]);

    k = {$urandom, $urandom, $urandom, $urandom};
    s = expand(k);
    offer_key(k);
    rd(4'd10, d, e, lat);
    chki("rekey_stall_lat", lat, 10);
    chkd("rekey_rk10", d, s[10]);

    key_in    = {$urandom, $urandom, $urandom, $urandom};
    key_valid = 1'b1;
    rk_idx    = 4'd0;
    rk_req    = 1'b1;
    wait_ack(20, d, e, lat);
    end_read();
    chki("accept_rd0_lat", lat, 0);
    chkd("accept_rd0_old", d, k);
    wait_idle();

    k = {$urandom, $urandom, $urandom, $urandom};
    offer_key(k);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk1("midrst_key_ready", key_ready, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    tick();
    rk_idx = 4'd1;
    rk_req = 1'b1;
    nack  = 0;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rk_ack === 1'b1) nack++;
      if (done === 1'b1) ndone++;
    end
    tick();
    chki("midrst_stall_acks", nack, 0);
    chki("midrst_no_done", ndone, 0);
    k = {$urandom, $urandom, $urandom, $urandom};
    s = expand(k);
    offer_key(k);
    wait_ack(20, d, e, lat);
    end_read();
    chki("pend_rekey_lat", lat, 1);
    chkd("pend_rekey_rk1", d, s[1]);
    wait_idle();
    rd(4'd10, d, e, lat);
    chkd("after_rst_rk10", d, s[10]);

    offer_key('0);
    wait_done(lat);
    chki("zero_done_lat", lat, 10);
    rd(4'd1, d, e, lat);
    chkd("zero_rk1", d, Z_RK1);
    rd(4'd10, d, e, lat);
    chkd("zero_rk10", d, Z_RK10);

    idle = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      reset     = ($urandom_range(0, 59) == 0);
      key_valid = ($urandom_range(0, 5) == 0);
      key_in    = {$urandom, $urandom, $urandom, $urandom};
      if (rk_req) begin
        if (rk_ack === 1'b1) begin
          rk_req = 1'b0;
          idle   = 1'b1;
        end
      end else if (idle) begin
        idle = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        rk_req = 1'b1;
        rk_idx = 4'($urandom_range(0, 15));
      end
      tick();
    end
    reset     = 1'b0;
    key_valid = 1'b0;
    rk_req    = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
